// File: rtl/maxnet_pkg.sv
// Shared types and helpers for the MaxNet processing-unit sequencer.
package maxnet_pkg;

  localparam int unsigned NUM_LANES   = 4;
  localparam logic [31:0] FP_MAG_MASK = 32'h7FFF_FFFF;

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DRAIN, CHECK, DONE} state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] row;
  } pu_tag_t;

  // Sign bit is ignored so that -0.0 counts as zero.
  function automatic logic is_zero(input logic [31:0] v);
    return (v & FP_MAG_MASK) == '0;
  endfunction

endpackage

// File: rtl/pu_tag_pipe.sv
// Delay line of {valid,row} tags matching the processing-unit latency,
// so each pu_out result can be steered to its row without cycle counting.
module pu_tag_pipe
  import maxnet_pkg::*;
#(
  parameter int unsigned PU_LAT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [1:0] in_row,
  output logic       out_valid,
  output logic [1:0] out_row
);

  pu_tag_t pipe [PU_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < PU_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {in_valid, in_row};
      for (int unsigned i = 1; i < PU_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign out_valid = pipe[PU_LAT-1].valid;
  assign out_row   = pipe[PU_LAT-1].row;

endmodule

// File: rtl/maxnet_pu_sequencer.sv
// Iteration controller for the 4-lane MaxNet processing unit: issues weight
// rows, collects tagged results and stops on convergence or iteration limit.
module maxnet_pu_sequencer
  import maxnet_pkg::*;
#(
  parameter int unsigned PU_LAT   = 4,
  parameter int unsigned MAX_ITER = 15,
  parameter int unsigned ITER_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [127:0]      init_vals,
  output logic [127:0]      pu_a,
  output logic [1:0]        w_sel,
  output logic              issue,
  input  logic [31:0]       pu_out,
  output logic              busy,
  output logic              done,
  output logic [1:0]        winner,
  output logic              winner_valid,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_cnt,
  output logic [127:0]      result
);

  state_e              state;
  logic [127:0]        nxt;
  logic                tag_valid;
  logic [1:0]          tag_row;
  logic [2:0]          nz_cnt;
  logic [1:0]          nz_idx;
  logic [ITER_W-1:0]   iter_inc;
  logic                stop;

  pu_tag_pipe #(.PU_LAT(PU_LAT)) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (issue),
    .in_row    (w_sel),
    .out_valid (tag_valid),
    .out_row   (tag_row)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) nxt <= '0;
    else if (tag_valid) nxt[32*tag_row +: 32] <= pu_out;
  end

  always_comb begin
    nz_cnt = '0;
    nz_idx = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (!is_zero(nxt[32*i +: 32])) begin
        nz_cnt = nz_cnt + 3'd1;
        nz_idx = i[1:0];
      end
    end
  end

  assign iter_inc = (iter_cnt == ITER_W'(MAX_ITER)) ? iter_cnt : iter_cnt + ITER_W'(1);
  assign stop     = (nz_cnt <= 3'd1) || (iter_inc == ITER_W'(MAX_ITER));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pu_a         <= '0;
      result       <= '0;
      w_sel        <= '0;
      issue        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      winner       <= '0;
      winner_valid <= 1'b0;
      timeout      <= 1'b0;
      iter_cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= LOAD;
            busy         <= 1'b1;
            iter_cnt     <= '0;
            timeout      <= 1'b0;
            winner_valid <= 1'b0;
          end
        end
        LOAD: begin
          pu_a  <= init_vals;
          issue <= 1'b1;
          w_sel <= '0;
          state <= ISSUE;
        end
        ISSUE: begin
          if (w_sel == 2'd3) begin
            issue <= 1'b0;
            w_sel <= '0;
            state <= DRAIN;
          end else begin
            w_sel <= w_sel + 2'd1;
          end
        end
        // Rows issue in order, so the row-3 tag is the last result of the iteration.
        DRAIN: begin
          if (tag_valid && tag_row == 2'd3) state <= CHECK;
        end
        CHECK: begin
          pu_a     <= nxt;
          iter_cnt <= iter_inc;
          if (stop) begin
            state        <= DONE;
            done         <= 1'b1;
            result       <= nxt;
            winner_valid <= (nz_cnt == 3'd1);
            winner       <= (nz_cnt == 3'd1) ? nz_idx : 2'd0;
            timeout      <= (nz_cnt > 3'd1);
          end else begin
            state <= ISSUE;
            issue <= 1'b1;
            w_sel <= '0;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_pu_sequencer.sv
// Directed bench for maxnet_pu_sequencer: three instances (PU_LAT 4/1/7),
// each fed by a scripted fixed-latency processing-unit stub.
`timescale 1ns/1ps
module tb_maxnet_pu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [127:0] init_vals;
  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;

  logic         start_a, issue_a, busy_a, done_a, winner_valid_a, timeout_a;
  logic [127:0] pu_a_a, result_a;
  logic [1:0]   w_sel_a, winner_a;
  logic [3:0]   iter_cnt_a;
  logic [31:0]  pu_out_a;

  logic         start_b, issue_b, busy_b, done_b, winner_valid_b, timeout_b;
  logic [127:0] pu_a_b, result_b;
  logic [1:0]   w_sel_b, winner_b;
  logic [3:0]   iter_cnt_b;
  logic [31:0]  pu_out_b;

  logic         start_c, issue_c, busy_c, done_c, winner_valid_c, timeout_c;
  logic [127:0] pu_a_c, result_c;
  logic [1:0]   w_sel_c, winner_c;
  logic [3:0]   iter_cnt_c;
  logic [31:0]  pu_out_c;

  maxnet_pu_sequencer #(.PU_LAT(4), .MAX_ITER(3), .ITER_W(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .init_vals(init_vals),
    .pu_a(pu_a_a), .w_sel(w_sel_a), .issue(issue_a), .pu_out(pu_out_a),
    .busy(busy_a), .done(done_a), .winner(winner_a), .winner_valid(winner_valid_a),
    .timeout(timeout_a), .iter_cnt(iter_cnt_a), .result(result_a)
  );

  maxnet_pu_sequencer #(.PU_LAT(1), .MAX_ITER(15), .ITER_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .init_vals(init_vals),
    .pu_a(pu_a_b), .w_sel(w_sel_b), .issue(issue_b), .pu_out(pu_out_b),
    .busy(busy_b), .done(done_b), .winner(winner_b), .winner_valid(winner_valid_b),
    .timeout(timeout_b), .iter_cnt(iter_cnt_b), .result(result_b)
  );

  maxnet_pu_sequencer #(.PU_LAT(7), .MAX_ITER(15), .ITER_W(4)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .init_vals(init_vals),
    .pu_a(pu_a_c), .w_sel(w_sel_c), .issue(issue_c), .pu_out(pu_out_c),
    .busy(busy_c), .done(done_c), .winner(winner_c), .winner_valid(winner_valid_c),
    .timeout(timeout_c), .iter_cnt(iter_cnt_c), .result(result_c)
  );

  // Stubs: the k-th issue of a run returns scr[k] exactly LAT cycles later.
  logic [31:0] scr_a [16];
  logic [31:0] scr_b [16];
  logic [31:0] scr_c [16];
  logic [31:0] dl_a  [4];
  logic [31:0] dl_b;
  logic [31:0] dl_c  [7];
  logic [3:0]  k_a, k_b, k_c;

  always @(posedge clk) begin
    for (int i = 3; i > 0; i--) dl_a[i] <= dl_a[i-1];
    dl_a[0] <= issue_a ? scr_a[k_a] : 32'hDEAD_BEEF;
    if (start_a && !busy_a) k_a <= 4'd0;
    else if (issue_a)       k_a <= k_a + 4'd1;
  end
  assign pu_out_a = dl_a[3];

  always @(posedge clk) begin
    dl_b <= issue_b ? scr_b[k_b] : 32'hDEAD_BEEF;
    if (start_b && !busy_b) k_b <= 4'd0;
    else if (issue_b)       k_b <= k_b + 4'd1;
  end
  assign pu_out_b = dl_b;

  always @(posedge clk) begin
    for (int i = 6; i > 0; i--) dl_c[i] <= dl_c[i-1];
    dl_c[0] <= issue_c ? scr_c[k_c] : 32'hDEAD_BEEF;
    if (start_c && !busy_c) k_c <= 4'd0;
    else if (issue_c)       k_c <= k_c + 4'd1;
  end
  assign pu_out_c = dl_c[6];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  // Leaves the bench in cycle 0, the cycle whose closing edge samples start.
  task automatic pulse_start(input int id);
    @(posedge clk);
    #1;
    cyc = 0;
    case (id)
      0:       start_a = 1'b1;
      1:       start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
  endtask

  function automatic logic done_of(input int id);
    case (id)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  task automatic wait_done(input int id, input int bound);
    while (done_of(id) !== 1'b1 && cyc < bound) step();
    check("done_seen", {127'b0, done_of(id)}, 128'd1);
  endtask

  logic activity;

  initial begin
    rst_n = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    init_vals = '0;
    for (int i = 0; i < 16; i++) begin
      scr_a[i] = '0; scr_b[i] = '0; scr_c[i] = '0;
    end
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl_a", {busy_a, done_a, issue_a, w_sel_a, winner_a, winner_valid_a, timeout_a, iter_cnt_a}, '0);
    check("rst_pu_a_a", pu_a_a, '0);
    check("rst_result_a", result_a, '0);
    check("rst_ctl_bc", {busy_b, busy_c, issue_b, issue_c, done_b, done_c}, '0);
    rst_n = 1'b1;
    init_vals = {32'h3E00_0000, 32'h3E80_0000, 32'h3F00_0000, 32'h3F80_0000};

    // Single winner after one iteration
    scr_a[0] = 32'h0; scr_a[1] = 32'h0; scr_a[2] = 32'h3E00_0000; scr_a[3] = 32'h0;
    pulse_start(0);
    step();
    check("t1_load_busy", busy_a, 1'b1);
    check("t1_load_issue", issue_a, 1'b0);
    step();
    check("t1_c2_issue", {issue_a, w_sel_a}, 3'b100);
    check("t1_c2_pu_a", pu_a_a, init_vals);
    repeat (3) step();
    check("t1_c5_issue", {issue_a, w_sel_a}, 3'b111);
    step();
    check("t1_c6_drain", issue_a, 1'b0);
    wait_done(0, 40);
    check("t1_done_cyc", cyc, 11);
    check("t1_winner", {winner_valid_a, winner_a}, 3'b110);
    check("t1_iter", iter_cnt_a, 4'd1);
    check("t1_timeout", timeout_a, 1'b0);
    check("t1_result", result_a[95:64], 32'h3E00_0000);
    step();
    check("t1_after", {busy_a, done_a}, 2'b00);

    // All zero, including negative zero
    scr_a[0] = 32'h8000_0000; scr_a[1] = 32'h0; scr_a[2] = 32'h8000_0000; scr_a[3] = 32'h0;
    pulse_start(0);
    wait_done(0, 40);
    check("t3_done_cyc", cyc, 11);
    check("t3_winner", {winner_valid_a, winner_a}, 3'b000);
    check("t3_timeout", timeout_a, 1'b0);
    check("t3_result", result_a, {32'h0, 32'h8000_0000, 32'h0, 32'h8000_0000});

    // Two iterations
    scr_a[0] = 32'h3F00_0000; scr_a[1] = 32'h3E80_0000; scr_a[2] = 32'h3E00_0000; scr_a[3] = 32'h3D80_0000;
    scr_a[4] = 32'h3E80_0000; scr_a[5] = 32'h0;         scr_a[6] = 32'h0;         scr_a[7] = 32'h0;
    pulse_start(0);
    while (cyc < 10) step();
    check("t2_c10_issue", issue_a, 1'b0);
    step();
    check("t2_c11_issue", {issue_a, w_sel_a}, 3'b100);
    check("t2_c11_pu_a", pu_a_a, {32'h3D80_0000, 32'h3E00_0000, 32'h3E80_0000, 32'h3F00_0000});
    check("t2_c11_iter", iter_cnt_a, 4'd1);
    wait_done(0, 60);
    check("t2_done_cyc", cyc, 20);
    check("t2_winner", {winner_valid_a, winner_a}, 3'b100);
    check("t2_iter", iter_cnt_a, 4'd2);
    check("t2_result", result_a, {96'h0, 32'h3E80_0000});

    // Timeout at MAX_ITER=3, with ignored starts mid-run and in DONE
    for (int i = 0; i < 16; i++) scr_a[i] = 32'h3F80_0000;
    pulse_start(0);
    while (cyc < 15) step();
    start_a = 1'b1;
    wait_done(0, 80);
    check("t4_done_cyc", cyc, 29);
    check("t4_iter", iter_cnt_a, 4'd3);
    check("t4_flags", {timeout_a, winner_valid_a, winner_a}, 4'b1000);
    check("t4_result", result_a, {4{32'h3F80_0000}});
    start_a = 1'b1;
    step();
    check("t4_c30_busy", busy_a, 1'b0);
    step();
    check("t4_c31_ignored", {busy_a, issue_a}, 2'b00);
    pulse_start(0);
    step();
    check("t4_restart", {busy_a, timeout_a, iter_cnt_a}, 6'b100000);
    wait_done(0, 80);
    check("t4_restart_cyc", cyc, 29);

    // PU_LAT=1: six-cycle iteration, row mapping from tags
    scr_b[0] = 32'h3F80_0001; scr_b[1] = 32'h3F80_0002; scr_b[2] = 32'h3F80_0003; scr_b[3] = 32'h3F80_0004;
    scr_b[4] = 32'h0;         scr_b[5] = 32'h0;         scr_b[6] = 32'h0;         scr_b[7] = 32'h4040_0000;
    pulse_start(1);
    while (cyc < 7) step();
    check("b_c7_issue", issue_b, 1'b0);
    step();
    check("b_c8_issue", {issue_b, w_sel_b}, 3'b100);
    check("b_c8_pu_a", pu_a_b, {32'h3F80_0004, 32'h3F80_0003, 32'h3F80_0002, 32'h3F80_0001});
    wait_done(1, 40);
    check("b_done_cyc", cyc, 14);
    check("b_winner", {winner_valid_b, winner_b, iter_cnt_b}, 7'b111_0010);
    check("b_result", result_b, {32'h4040_0000, 96'h0});

    // PU_LAT=7: twelve-cycle iteration
    scr_c[0] = 32'h4000_0001; scr_c[1] = 32'h4000_0002; scr_c[2] = 32'h4000_0003; scr_c[3] = 32'h4000_0004;
    scr_c[4] = 32'h0;         scr_c[5] = 32'h3F80_0000; scr_c[6] = 32'h0;         scr_c[7] = 32'h0;
    pulse_start(2);
    while (cyc < 13) step();
    check("c_c13_issue", issue_c, 1'b0);
    step();
    check("c_c14_issue", {issue_c, w_sel_c}, 3'b100);
    check("c_c14_pu_a", pu_a_c, {32'h4000_0004, 32'h4000_0003, 32'h4000_0002, 32'h4000_0001});
    wait_done(2, 60);
    check("c_done_cyc", cyc, 26);
    check("c_winner", {winner_valid_c, winner_c, iter_cnt_c}, 7'b101_0010);
    check("c_result", result_c, {64'h0, 32'h3F80_0000, 32'h0});

    // Asynchronous reset in the middle of ISSUE
    for (int i = 0; i < 16; i++) scr_a[i] = 32'h3F80_0000;
    pulse_start(0);
    repeat (3) step();
    check("mr_pre", {busy_a, issue_a, w_sel_a}, 4'b1101);
    rst_n = 1'b0;
    #1;
    check("mr_busy", busy_a, 1'b0);
    check("mr_issue", {issue_a, w_sel_a}, 3'b000);
    check("mr_pu_a", pu_a_a, '0);
    check("mr_result", result_a, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    activity = 1'b0;
    repeat (12) begin
      step();
      activity = activity | busy_a | done_a | issue_a | (result_a != '0) | (iter_cnt_a != '0);
    end
    check("mr_quiet", activity, 1'b0);
    scr_a[0] = 32'h0; scr_a[1] = 32'h0; scr_a[2] = 32'h3E00_0000; scr_a[3] = 32'h0;
    pulse_start(0);
    wait_done(0, 40);
    check("mr_recover_cyc", cyc, 11);
    check("mr_recover_win", {winner_valid_a, winner_a}, 3'b110);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=stalled exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
